cpu_control_unit: RTL

- Hardwired Moore control unit that sequences the phase-2 CPU datapath: instruction fetch, decode and execute for the load/store, ALU register, ALU immediate, nop and halt instructions.
- Drives the datapath strobes (bus-out selects, register enables, Gra/Grb/Grc, ALU op, memory Read/Write).
- Waits on a memory ready handshake.
- Replaces testbench-driven sequencing of the datapath.

---
 rtl/cpu_control_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cpu_control_unit.sv
// Hardwired Moore control unit sequencing fetch/decode/execute for the phase-2 datapath.
// State is registered; every strobe is a combinational decode of state and ir.
module cpu_control_unit #(
  parameter logic [4:0] ADD_OP = 5'b00011,
  parameter logic [4:0] SUB_OP = 5'b00100,
  parameter logic [4:0] AND_OP = 5'b00101,
  parameter logic [4:0] OR_OP  = 5'b00110
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        ZLowOut,
  output logic        MDRout,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Rin,
  output logic        IncPC,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic [4:0]  alu_op,
  output logic        Read,
  output logic        Write,
  output logic        run,
  output logic [3:0]  state
);

  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_T0    = 4'd1;
  localparam logic [3:0] S_T1    = 4'd2;
  localparam logic [3:0] S_T1W   = 4'd3;
  localparam logic [3:0] S_T2    = 4'd4;
  localparam logic [3:0] S_T3    = 4'd5;
  localparam logic [3:0] S_T4    = 4'd6;
  localparam logic [3:0] S_T5    = 4'd7;
  localparam logic [3:0] S_T6    = 4'd8;
  localparam logic [3:0] S_T7    = 4'd9;
  localparam logic [3:0] S_HALT  = 4'd10;

  localparam logic [4:0] OPC_LD   = 5'b00000;
  localparam logic [4:0] OPC_LDI  = 5'b00001;
  localparam logic [4:0] OPC_ST   = 5'b00010;
  localparam logic [4:0] OPC_ADDI = 5'b01100;
  localparam logic [4:0] OPC_ANDI = 5'b01101;
  localparam logic [4:0] OPC_ORI  = 5'b01110;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  logic [3:0] next_state;
  logic [4:0] opcode;
  logic       is_ld, is_ldi, is_st, is_mem, is_rtype, is_imm, is_halt;
  logic [4:0] imm_op;
  logic       unused_ir_bits;

  assign opcode         = ir[31:27];
  assign unused_ir_bits = ^ir[26:0];
  assign is_ld    = (opcode == OPC_LD);
  assign is_ldi   = (opcode == OPC_LDI);
  assign is_st    = (opcode == OPC_ST);
  assign is_mem   = is_ld | is_ldi | is_st;
  assign is_rtype = (opcode == ADD_OP) | (opcode == SUB_OP) |
                    (opcode == AND_OP) | (opcode == OR_OP);
  assign is_imm   = (opcode == OPC_ADDI) | (opcode == OPC_ANDI) | (opcode == OPC_ORI);
  assign is_halt  = (opcode == OPC_HALT);

  always_comb begin
    imm_op = ADD_OP;
    if (opcode == OPC_ANDI)     imm_op = AND_OP;
    else if (opcode == OPC_ORI) imm_op = OR_OP;
  end

  always_ff @(posedge clk) begin
    if (clr) state <= S_RESET;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_RESET: next_state = S_T0;
      S_T0:    next_state = S_T1;
      S_T1:    next_state = mem_ready ? S_T2 : S_T1W;
      S_T1W:   next_state = mem_ready ? S_T2 : S_T1W;
      S_T2:    next_state = S_T3;
      S_T3: begin
        if (is_halt)                       next_state = S_HALT;
        else if (is_mem | is_rtype | is_imm) next_state = S_T4;
        else                               next_state = S_T0;
      end
      S_T4:    next_state = S_T5;
      S_T5:    next_state = (is_ld | is_st) ? S_T6 : S_T0;
      // ld waits for the read in T6; st waits for the write in T7
      S_T6:    next_state = is_st ? S_T7 : (is_ld ? (mem_ready ? S_T7 : S_T6) : S_T0);
      S_T7:    next_state = is_st ? (mem_ready ? S_T0 : S_T7) : S_T0;
      S_HALT:  next_state = S_HALT;
      default: next_state = S_RESET;
    endcase
  end

  always_comb begin
    {PCout, ZLowOut, MDRout, Rout, BAout, Cout} = '0;
    {MARin, PCin, MDRin, IRin, Yin, Zin, Rin}   = '0;
    {IncPC, Gra, Grb, Grc, Read, Write}         = '0;
    alu_op = '0;
    run    = (state != S_RESET) && (state != S_HALT);
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin ZLowOut = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T1W: begin Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (is_mem) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (is_rtype | is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end
      end
      S_T4: begin
        Zin = 1'b1;
        if (is_mem) begin
          Cout = 1'b1; alu_op = ADD_OP;
        end else if (is_rtype) begin
          Grc = 1'b1; Rout = 1'b1; alu_op = opcode;
        end else if (is_imm) begin
          Cout = 1'b1; alu_op = imm_op;
        end
      end
      S_T5: begin
        ZLowOut = 1'b1;
        if (is_ld | is_st) MARin = 1'b1;
        else begin Gra = 1'b1; Rin = 1'b1; end
      end
      S_T6: begin
        MDRin = 1'b1;
        if (is_st) begin Gra = 1'b1; Rout = 1'b1; end
        else       Read = 1'b1;
      end
      S_T7: begin
        if (is_st) Write = 1'b1;
        else begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      end
      default: ;
    endcase
  end

endmodule
